// File: rtl/noise_gen_lfsr.sv
// noise_gen_lfsr: 15-bit Fibonacci LFSR noise source for the synth voice path.
// The LFSR advances once every `period` enabled clocks. `mode` selects long
// (taps 0,1) or short (taps 0,6) feedback. A run-time seed can be loaded, and
// `tick` pulses in the cycle after each advance.
module noise_gen_lfsr #(
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned PERIOD_W = 32,
    parameter logic [14:0] SEED     = 15'h0001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                mode,
    input  logic                load,
    input  logic [14:0]         seed_in,
    output logic [OUT_W-1:0]    value,
    output logic                bit_out,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [14:0]         lfsr_q, lfsr_d;
    logic [PERIOD_W-1:0] cnt_q,  cnt_d;
    logic                tick_q, tick_d;
    logic                fb;

    // Feedback bit and next-state selection, following the load > gate > step > count priority
    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        fb     = lfsr_q[0] ^ (mode ? lfsr_q[6] : lfsr_q[1]);
        if (load) begin
            // A zero seed would lock the register, so fall back to SEED instead
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
            cnt_d  = '0;
        end else if (!enable || (period == '0)) begin
            // Hold the count and the LFSR. tick is already defaulted low.
        end else if (cnt_q == '0) begin
            lfsr_d = {fb, lfsr_q[14:1]};
            cnt_d  = period - ONE;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q - ONE;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign value   = lfsr_q[OUT_W-1:0];
    assign bit_out = ~lfsr_q[0];
    assign tick    = tick_q;

endmodule

// File: tb/tb_noise_gen_lfsr.sv
// Testbench for noise_gen_lfsr. It drives a default-width instance and an
// OUT_W=15 / PERIOD_W=4 instance side by side, and checks both against a
// behavioural model.
module tb_noise_gen_lfsr;

    logic        clk = 1'b0;
    logic        reset, enable, mode, load;
    logic [14:0] seed_in;
    logic [31:0] period_a;
    logic [3:0]  period_b;
    logic [7:0]  value_a;
    logic        bit_a, tick_a;
    logic [14:0] value_b;
    logic        bit_b, tick_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    noise_gen_lfsr u_a (
        .clk(clk), .reset(reset), .enable(enable), .period(period_a),
        .mode(mode), .load(load), .seed_in(seed_in),
        .value(value_a), .bit_out(bit_a), .tick(tick_a)
    );

    noise_gen_lfsr #(.OUT_W(15), .PERIOD_W(4)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .period(period_b),
        .mode(mode), .load(load), .seed_in(seed_in),
        .value(value_b), .bit_out(bit_b), .tick(tick_b)
    );

    // Model state: the LFSR contents as an integer, the number of qualifying
    // edges still to pass before the next advance, and the pending tick flag.
    typedef struct {
        int unsigned lfsr;
        int unsigned left;
        bit          tick;
    } m_t;

    m_t ma, mb;

    // Advance the LFSR: shift right and insert bit0 ^ tap at bit 14
    function automatic int unsigned lfsr_next(int unsigned x, bit md);
        int unsigned tap;
        int unsigned fb;
        tap = md ? 6 : 1;
        fb  = (x ^ (x >> tap)) & 1;
        return (x >> 1) | (fb << 14);
    endfunction

    // Apply one clock edge to the model
    function automatic m_t model_edge(m_t s, bit rst, bit ld, int unsigned seed,
                                      bit en, int unsigned per, bit md);
        m_t r;
        r = s;
        r.tick = 1'b0;
        if (rst) begin
            r.lfsr = 1; r.left = 0;
        end else if (ld) begin
            r.lfsr = (seed == 0) ? 1 : seed; r.left = 0;
        end else if (en && per != 0) begin
            if (s.left == 0) begin
                r.lfsr = lfsr_next(s.lfsr, md);
                r.left = per - 1;
                r.tick = 1'b1;
            end else begin
                r.left = s.left - 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the models with the inputs present at the edge, then check both DUTs
    task automatic cycle();
        @(posedge clk);
        ma = model_edge(ma, reset, load, seed_in, enable, period_a, mode);
        mb = model_edge(mb, reset, load, seed_in, enable, period_b, mode);
        #1;
        chk("value_a", value_a, ma.lfsr & 8'hFF);
        chk("bit_a",   bit_a,   ~ma.lfsr & 1);
        chk("tick_a",  tick_a,  ma.tick);
        chk("value_b", value_b, mb.lfsr);
        chk("bit_b",   bit_b,   ~mb.lfsr & 1);
        chk("tick_b",  tick_b,  mb.tick);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int lows;
        int zeros;
        int gap;
        int changes;
        logic [14:0] held;

        ma = '{lfsr: 0, left: 0, tick: 0};
        mb = '{lfsr: 0, left: 0, tick: 0};
        reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0; seed_in = '0;
        period_a = 32'd4; period_b = 4'd4;

        // Reset state
        cycle();
        cycle();
        chk("rst_value", value_a, 8'h01);
        chk("rst_bit",   bit_a,   0);
        chk("rst_tick",  tick_a,  0);

        // Reset-and-step with period 4: advances on enabled edges 1, 5, 9
        reset = 1'b0; enable = 1'b1;
        cycle();
        chk("step1_lfsr", value_b, 15'h4000);
        chk("step1_val8", value_a, 8'h00);
        chk("step1_tick", tick_a, 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("gap_tick", tick_a, 0);
        cycle();
        chk("step2_lfsr", value_b, 15'h2000);
        chk("step2_tick", tick_a, 1);
        for (int i = 0; i < 4; i++) cycle();
        chk("step3_lfsr", value_b, 15'h1000);

        // Long mode returns to the seed after exactly 32767 steps
        period_a = 32'd1; period_b = 4'd1; mode = 1'b0;
        do_reset();
        n = 0; lows = 0;
        do begin
            cycle();
            n++;
            if (!tick_a) lows++;
        end while (value_b != 15'h0001 && n < 40000);
        chk("long_period", n, 32767);
        chk("long_tick_lows", lows, 0);

        // Short mode repeats every 93 steps and never reaches zero
        mode = 1'b1;
        do_reset();
        n = 0; zeros = 0;
        do begin
            cycle();
            n++;
            if (value_b == 15'h0000) zeros++;
        end while (value_b != 15'h0001 && n < 200);
        chk("short_period", n, 93);
        chk("short_zero", zeros, 0);

        // A zero-seed load on a due-step edge wins, and the step follows on the next edge
        mode = 1'b0; period_a = 32'd4; period_b = 4'd4;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        load = 1'b1; seed_in = '0;
        cycle();
        chk("load_lfsr", value_b, 15'h0001);
        chk("load_tick", tick_a, 0);
        load = 1'b0;
        cycle();
        chk("post_load_tick", tick_a, 1);
        chk("post_load_lfsr", value_b, 15'h4000);

        // period 0 halts stepping
        period_a = '0; period_b = '0;
        held = value_b; changes = 0; n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (value_b != held) changes++;
            if (tick_a || tick_b) n++;
        end
        chk("halt_changes", changes, 0);
        chk("halt_ticks", n, 0);

        // With period 8, dropping enable for 3 clocks delays the next tick by 3
        period_a = 32'd8; period_b = 4'd8;
        do_reset();
        cycle();
        chk("gate_first_tick", tick_a, 1);
        gap = 0;
        for (int i = 0; i < 2; i++) begin cycle(); gap++; end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin cycle(); gap++; end
        enable = 1'b1;
        do begin cycle(); gap++; end while (!tick_a && gap < 40);
        chk("gate_gap", gap, 11);

        // Width generality: period 15 on the 4-bit-period instance
        period_a = 32'd15; period_b = 4'd15;
        do_reset();
        cycle();
        gap = 0;
        do begin cycle(); gap++; end while (!tick_b && gap < 40);
        chk("wide_gap", gap, 15);
        gap = 0;
        do begin cycle(); gap++; end while (!tick_b && gap < 40);
        chk("wide_gap2", gap, 15);

        // Randomised mix of enable, mode, period, load and occasional reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            mode     = $urandom_range(0, 1);
            load     = ($urandom_range(0, 19) == 0);
            seed_in  = ($urandom_range(0, 2) == 0) ? 15'h0000 : 15'($urandom);
            reset    = ($urandom_range(0, 49) == 0);
            period_a = 32'($urandom_range(0, 5));
            period_b = period_a[3:0];
            cycle();
        end
        reset = 1'b0; load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
